// File: rtl/medidor_periodo.sv
// Period meter for a slow asynchronous input: counts clk cycles between rising edges of clk_in.
// Optional edge timeout is built when MEDIDOR_TIMEOUT_EN is defined.
module medidor_periodo #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
`ifdef MEDIDOR_TIMEOUT_EN
  , parameter int TIMEOUT   = 65535
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_in,
  input  logic             start,
  input  logic             continuo,
  input  logic             ack,
  output logic [WIDTH-1:0] periodo,
  output logic             valid,
  output logic             saturado,
  output logic             perdido,
  output logic             ocupado,
  output logic             sem_sinal
);

  typedef enum logic [1:0] {IDLE, ARM, MEDE, PRONTO} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   edge_det;
  logic [WIDTH-1:0]       cnt;
  logic                   sat;
  logic                   capture;
  logic                   cnt_load;
  logic                   cnt_en;
  logic                   timeout_hit;

  // NOTE: the reset here is synchronous, so rst_n lives inside the clocked branch, not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge value of its neighbour.
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk_in};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~s_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:   if (start)                 state_next = ARM;
      ARM:    if (edge_det)              state_next = MEDE;
      MEDE:   if (edge_det && !continuo) state_next = PRONTO;
      PRONTO: if (ack)                   state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
    if (timeout_hit) state_next = IDLE;
  end

  always_comb begin
    capture  = (state == MEDE) && edge_det;
    cnt_load = ((state == ARM) && edge_det) || (capture && continuo);
    cnt_en   = (state == MEDE) && !edge_det;
    ocupado  = (state != IDLE);
  end

  // Period counter: starts at 1 on the opening edge so the closing edge reads exactly P.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (cnt_load) begin
      cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
      sat <= 1'b0;
    end else if (cnt_en) begin
      if (cnt == CNT_MAX) sat <= 1'b1;
      else                cnt <= cnt + 1'b1;
    end
  end

  // A capture coinciding with ack keeps the fresh result valid and counts nothing as lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      periodo  <= '0;
      saturado <= 1'b0;
      valid    <= 1'b0;
      perdido  <= 1'b0;
    end else if (capture) begin
      periodo  <= cnt;
      saturado <= sat;
      valid    <= 1'b1;
      perdido  <= ack ? 1'b0 : (perdido | valid);
    end else if (ack && valid) begin
      valid    <= 1'b0;
      perdido  <= 1'b0;
    end
  end

`ifdef MEDIDOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          waiting;

  assign waiting     = (state == ARM) || (state == MEDE);
  assign timeout_hit = waiting && !edge_det && (tmo_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt   <= '0;
      sem_sinal <= 1'b0;
    end else begin
      if (edge_det || ((state == IDLE) && start)) tmo_cnt <= '0;
      else if (waiting && !timeout_hit)           tmo_cnt <= tmo_cnt + 1'b1;

      if (timeout_hit)                     sem_sinal <= 1'b1;
      else if ((state == IDLE) && start)   sem_sinal <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign sem_sinal   = 1'b0;
`endif

endmodule
